msrv32_wr_en_ctrl: RTL and testbench
====================================

Name: msrv32_wr_en_ctrl

Overview:
- Parametrised multi-channel write-enable controller for the msrv32 writeback path.
- Generalises the single-cycle flush gating of the integer-RF and CSR write enables to NUM_CH channels.
- Adds a configurable pipeline delay, stall hold, a post-flush hold-off window and per-channel squash counters for debug/perf.
- Sits between the WB-stage register outputs and the register file / CSR file write ports.

Parameters:
NUM_CH, 2, number of write-enable channels (ch0 = integer RF, ch1 = CSR by convention); 1..8
PIPE_STAGES, 1, register stages between wr_en_req_in and wr_en_out; 1..4
FLUSH_HOLD, 2, cycles after a flush during which new requests are dropped; 0..15
CNT_W, 8, width of each per-channel squash counter

Ports:
ms_riscv32_mp_clk_in  input  1  clock, all state on rising edge
ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low
wr_en_req_in  input  NUM_CH  per-channel write request from WB stage
flush_in  input  1  pipeline flush (trap, branch mispredict)
stall_in  input  1  pipeline stall; in-flight requests hold
clr_cnt_in  input  1  synchronous clear of all squash counters
wr_en_out  output  NUM_CH  gated write enables to RF/CSR files
hold_active_out  output  1  high while in HOLD state
squash_cnt_out  output  NUM_CH*CNT_W  packed counters, ch i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst low, async): all pipe stages 0, state RUN, hold counter 0, all squash counters 0; wr_en_out 0, hold_active_out 0.
- Pipeline: stage[0] captures the entry-gated wr_en_req_in; stage[k] captures stage[k-1]. Request at edge t appears on stage[PIPE_STAGES-1] after PIPE_STAGES edges.
- wr_en_out = stage[PIPE_STAGES-1] & ~stall_in & ~flush_in (combinational gate on a registered value). A flush kills the write in the same cycle.
- Stall (flush low): all stages hold their value. wr_en_out = 0, so a stalled write is never issued twice; it issues on the first unstalled cycle.
- Entry gate: wr_en_req_in is accepted only when state == RUN, flush_in = 0 and stall_in = 0. While stalled, stage[0] holds and new requests are ignored; upstream also holds.
- Flush: at the next edge all stages clear to 0. Flush overrides stall.
- FSM:
  - RUN -> HOLD on flush_in when FLUSH_HOLD > 0; hold counter loads FLUSH_HOLD.
  - HOLD: counter decrements each edge, stall notwithstanding. HOLD -> RUN when the counter reaches 1 and decrements.
  - flush_in in HOLD reloads the counter to FLUSH_HOLD.
  - FLUSH_HOLD = 0: FSM stays in RUN; only same-cycle squash applies.
- hold_active_out = (state == HOLD), registered.
- Squash counting, per channel i, per cycle (flush_in or state == HOLD): counter increments by 1 if any of the following was lost that cycle:
  - any set bit of channel i in any stage cleared by flush_in;
  - wr_en_req_in[i] dropped at entry.
  - Maximum one increment per channel per cycle.
  - Stall-dropped entry requests are not counted.
- Counters saturate at 2^CNT_W-1 with no wrap.
- clr_cnt_in wins over a simultaneous increment: the counter becomes 0.
- Reset mid-HOLD or mid-pipeline returns to the reset values immediately; no pending write survives.

Test Plan:
- Reset/latency: NUM_CH=2, PIPE_STAGES=2. Release reset, pulse wr_en_req_in=2'b01 at cycle 3 -> wr_en_out=2'b01 at cycle 5 for one cycle; all outputs 0 during reset.
- Same-cycle flush: with stage[last]=2'b11, assert flush_in -> wr_en_out=2'b00 that cycle, stages 0 next edge. Both squash counters increment to 1 and hold_active_out=1 for 2 cycles (FLUSH_HOLD=2).
- Hold-off drop: during HOLD drive wr_en_req_in=2'b10 both cycles -> no write ever issues, ch1 counter +2, ch0 unchanged; the request on the first RUN cycle issues normally.
- Stall: stage[last]=2'b01, stall_in high 3 cycles -> wr_en_out 0 for those 3 cycles, then 2'b01 exactly once; counters unchanged.
- Saturation/clear: CNT_W=2, 5 flushes each killing ch0 -> ch0 counter reads 3. clr_cnt_in asserted with a simultaneous flush -> counter 0.
- Async reset mid-HOLD: drop rst mid-cycle during HOLD -> hold_active_out, stages and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/msrv32_wr_en_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_wr_en_ctrl
//
// Multi-channel write-enable controller for the msrv32 writeback path. Each
// channel's write request travels through PIPE_STAGES register stages before
// it reaches the register-file / CSR-file write port. Flushes kill in-flight
// writes in the same cycle. Stalls freeze the pipe and suppress the output so
// a write never issues twice. A post-flush hold-off window (FLUSH_HOLD cycles)
// drops new requests. Per-channel saturating counters record lost writes.
//
// Handshake: there is no valid/ready pair. wr_en_req_in is sampled on a rising
// edge only when the entry gate is open (state RUN, no flush, no stall). While
// stalled the upstream stage is expected to hold its request steady and
// re-present it.
//
// Ports:
//   ms_riscv32_mp_clk_in  - clock, all state on the rising edge
//   ms_riscv32_mp_rst_in  - asynchronous active-low reset
//   wr_en_req_in          - per-channel write request from the WB stage
//   flush_in              - pipeline flush (trap, branch mispredict)
//   stall_in              - pipeline stall, in-flight requests hold
//   clr_cnt_in            - synchronous clear of all squash counters
//   wr_en_out             - gated write enables to the RF / CSR files
//   hold_active_out       - high while the FSM is in HOLD (FSM state view)
//   squash_cnt_out        - packed counters, channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module msrv32_wr_en_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int PIPE_STAGES = 1,
    parameter int FLUSH_HOLD  = 2,
    parameter int CNT_W       = 8
) (
    input  logic                      ms_riscv32_mp_clk_in,
    input  logic                      ms_riscv32_mp_rst_in,
    input  logic [NUM_CH-1:0]         wr_en_req_in,
    input  logic                      flush_in,
    input  logic                      stall_in,
    input  logic                      clr_cnt_in,
    output logic [NUM_CH-1:0]         wr_en_out,
    output logic                      hold_active_out,
    output logic [NUM_CH*CNT_W-1:0]   squash_cnt_out
);

    localparam int HCNT_W = 4;
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(FLUSH_HOLD);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_CH-1:0]   stage_q [PIPE_STAGES];
    logic [NUM_CH-1:0]   stage_d [PIPE_STAGES];
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   stage_any;
    logic [NUM_CH-1:0]   lost;

    // ------------------------------------------------------------------
    // Pipeline next state. Flush beats stall; stall freezes every stage.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush_in) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_d[k] = '0;
            end
        end else if (!stall_in) begin
            stage_d[0] = (state_q == ST_RUN) ? wr_en_req_in : '0;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold-off FSM. A flush inside HOLD restarts the window.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_in && (FLUSH_HOLD > 0)) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (flush_in) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == HCNT_ONE) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HCNT_ONE;
                end
            end
            default: begin
                state_d    = ST_RUN;
                hold_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Squash accounting. A channel loses a write when a flush clears one of
    // its in-flight bits, or when its entry request is refused by a flush or
    // by the hold-off window. A request refused only because of a stall is
    // re-presented by upstream, so it is not a loss (hence the ~stall_in on
    // the HOLD term; a flush overrides the stall and is always a loss).
    // ------------------------------------------------------------------
    always_comb begin
        stage_any = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            stage_any = stage_any | stage_q[k];
        end
    end

    always_comb begin
        lost = ({NUM_CH{flush_in}} & stage_any) |
               (wr_en_req_in & {NUM_CH{flush_in | ((state_q == ST_HOLD) & ~stall_in)}});
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_cnt_in) begin
                cnt_d[i] = '0;
            end else if (lost[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_q[k] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The last stage is gated combinationally so a same-cycle
    // flush or stall suppresses the write before it reaches the file.
    // ------------------------------------------------------------------
    assign wr_en_out       = stage_q[PIPE_STAGES-1] & {NUM_CH{~stall_in & ~flush_in}};
    assign hold_active_out = (state_q == ST_HOLD);

    always_comb begin
        squash_cnt_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            squash_cnt_out[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_msrv32_wr_en_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msrv32_wr_en_ctrl
//
// Directed bench for msrv32_wr_en_ctrl with NUM_CH=2, PIPE_STAGES=2,
// FLUSH_HOLD=2, CNT_W=2. Each table row is one clock cycle: inputs are driven
// 1 ns after a rising edge and outputs are compared on the following falling
// edge, so a row's expected values are what the DUT shows during that cycle.
// ---------------------------------------------------------------------------
module tb_msrv32_wr_en_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req;
    logic       flush;
    logic       stall;
    logic       clr;
    logic [1:0] wr_en;
    logic       hold_active;
    logic [3:0] squash_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] req;
        logic       flush;
        logic       stall;
        logic       clr;
        logic [1:0] exp_wr;
        logic       exp_hold;
        logic [1:0] exp_c0;
        logic [1:0] exp_c1;
    } vec_t;

    vec_t vecs[$];

    msrv32_wr_en_ctrl #(
        .NUM_CH      (2),
        .PIPE_STAGES (2),
        .FLUSH_HOLD  (2),
        .CNT_W       (2)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .wr_en_req_in         (req),
        .flush_in             (flush),
        .stall_in             (stall),
        .clr_cnt_in           (clr),
        .wr_en_out            (wr_en),
        .hold_active_out      (hold_active),
        .squash_cnt_out       (squash_cnt)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic f, input logic s,
                                input logic c, input logic [1:0] w, input logic h,
                                input logic [1:0] c0, input logic [1:0] c1);
        vec_t v;
        v.req = r; v.flush = f; v.stall = s; v.clr = c;
        v.exp_wr = w; v.exp_hold = h; v.exp_c0 = c0; v.exp_c1 = c1;
        return v;
    endfunction

    task automatic check_outs(input string tag, input logic [1:0] w, input logic h,
                              input logic [1:0] c0, input logic [1:0] c1);
        check({tag, ".wr_en"}, 32'(wr_en), 32'(w));
        check({tag, ".hold"},  32'(hold_active), 32'(h));
        check({tag, ".cnt0"},  32'(squash_cnt[1:0]), 32'(c0));
        check({tag, ".cnt1"},  32'(squash_cnt[3:2]), 32'(c1));
    endtask

    // One cycle: drive after the rising edge, compare on the falling edge.
    task automatic apply(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        req   = v.req;
        flush = v.flush;
        stall = v.stall;
        clr   = v.clr;
        @(negedge clk);
        check_outs(tag, v.exp_wr, v.exp_hold, v.exp_c0, v.exp_c1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        //           req   fl    st    cl    wr    hold  c0    c1
        // latency: request in row 2 issues in row 4 only
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 0
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 1
        vecs.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 2
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 3
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 2'd0)); // 4
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 5
        // same-cycle flush of 2'b11 in the last stage
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 6
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 7
        vecs.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 8
        // hold-off: ch1 requests dropped twice, third one accepted
        vecs.push_back(mk(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 2'd1)); // 9
        vecs.push_back(mk(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 2'd2)); // 10
        vecs.push_back(mk(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 2'd3)); // 11
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 2'd3)); // 12
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'd1, 2'd3)); // 13
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 2'd3)); // 14
        // counter clear
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'd1, 2'd3)); // 15
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 16
        // stall: 2'b01 waits three cycles, issues once; stalled 2'b10 ignored
        vecs.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 17
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 18
        vecs.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 19
        vecs.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 20
        vecs.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 21
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 2'd0)); // 22
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 23
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 24
        // five flushes each killing ch0, saturation at 3, clear beats flush
        vecs.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 25
        vecs.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 26
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 2'd0)); // 27
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd2, 2'd0)); // 28
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd3, 2'd0)); // 29
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd3, 2'd0)); // 30
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 2'd3, 2'd0)); // 31
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0, 2'd0)); // 32
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0, 2'd0)); // 33
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0)); // 34

        // ---------------- reset with active inputs ----------------
        req = 2'b11; flush = 1'b0; stall = 1'b0; clr = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_outs("reset", 2'b00, 1'b0, 2'd0, 2'd0);
        end
        req = 2'b00;
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("row%0d", i), vecs[i]);
        end

        // ---------------- async reset mid-HOLD ----------------
        apply("rh_a", mk(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));
        apply("rh_b", mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));
        apply("rh_c", mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 2'd1));
        #1 rst_n = 1'b0;
        #1 check_outs("rh_async", 2'b00, 1'b0, 2'd0, 2'd0);
        #1 rst_n = 1'b1;
        apply("rh_d", mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));
        apply("rh_e", mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));

        // ---------------- async reset mid-pipeline ----------------
        apply("rp_a", mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));
        @(posedge clk);
        #1 req = 2'b00;
        #1 rst_n = 1'b0;
        #1 check_outs("rp_async", 2'b00, 1'b0, 2'd0, 2'd0);
        #1 rst_n = 1'b1;
        apply("rp_b", mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));
        apply("rp_c", mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));
        apply("rp_d", mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0));

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
